// File: rtl/ama_riscv_branch_compare_pipe.sv
// ama_riscv_branch_compare_pipe: pipelined RV branch comparator (MSB chunk first) with valid/ready and flush
// Ports: clk, rst_n (async active-low), flush (sync clear of in-flight entries);
//        input side  in_valid/in_ready carrying in_funct3, in_a, in_b, in_tag;
//        output side out_valid/out_ready carrying out_eq, out_lt, out_taken, out_err, out_tag.
module ama_riscv_branch_compare_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_taken,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CHUNK = XLEN / STAGES;
  logic [STAGES-1:0] v, adv, v_in, eq_in, lt_in, eq_n, lt_n, eq_q, lt_q;
  logic [2:0] f3_in [STAGES];
  logic [2:0] f3_q [STAGES];
  logic [TAG_W-1:0] tag_in [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [XLEN-1:0] a_in [STAGES];
  logic [XLEN-1:0] b_in [STAGES];
  logic [XLEN-1:0] a_q [STAGES];
  logic [XLEN-1:0] b_q [STAGES];
  logic [XLEN-1:0] sign_flip;
  logic [2:0] f3_last;
  logic rdy_q, taken_q, err_q, err_d, taken_d;
  // Flipping both sign bits turns a signed compare into an unsigned one
  assign sign_flip = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  // rdy_q keeps in_ready low during reset and until the first edge after release
  assign in_ready = adv[0] && !flush && rdy_q;
  always_comb begin
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int k = STAGES-2; k >= 0; k--) adv[k] = !v[k] || adv[k+1];
  end
  // Stage operands are kept left-aligned: each stage shifts out the chunk it consumed
  always_comb begin
    v_in[0]   = in_valid && in_ready;
    f3_in[0]  = in_funct3;
    tag_in[0] = in_tag;
    a_in[0]   = in_a ^ sign_flip;
    b_in[0]   = in_b ^ sign_flip;
    eq_in[0]  = 1'b1;
    lt_in[0]  = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]   = v[k-1];
      f3_in[k]  = f3_q[k-1];
      tag_in[k] = tag_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      eq_in[k]  = eq_q[k-1];
      lt_in[k]  = lt_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      eq_n[k] = eq_in[k] ? a_in[k][XLEN-1 -: CHUNK] == b_in[k][XLEN-1 -: CHUNK] : 1'b0;
      lt_n[k] = eq_in[k] ? a_in[k][XLEN-1 -: CHUNK] < b_in[k][XLEN-1 -: CHUNK] : lt_in[k];
    end
  end
  assign f3_last = f3_in[STAGES-1];
  assign err_d   = f3_last[2:1] == 2'b01;
  // funct3[2] selects lt vs eq, funct3[0] inverts
  assign taken_d = !err_d && ((f3_last[2] ? lt_n[STAGES-1] : eq_n[STAGES-1]) ^ f3_last[0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      rdy_q   <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        f3_q[k]  <= '0;
        tag_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (flush) v[k] <= 1'b0;
        else if (adv[k]) v[k] <= v_in[k];
        if (adv[k]) begin
          f3_q[k]  <= f3_in[k];
          tag_q[k] <= tag_in[k];
          eq_q[k]  <= eq_n[k];
          lt_q[k]  <= lt_n[k];
          a_q[k]   <= a_in[k] << CHUNK;
          b_q[k]   <= b_in[k] << CHUNK;
        end
      end
      if (adv[STAGES-1]) begin
        taken_q <= taken_d;
        err_q   <= err_d;
      end
    end
  end
  assign out_valid = v[STAGES-1];
  assign out_eq    = eq_q[STAGES-1];
  assign out_lt    = lt_q[STAGES-1];
  assign out_taken = taken_q;
  assign out_err   = err_q;
  assign out_tag   = tag_q[STAGES-1];
endmodule

// File: tb/tb_ama_riscv_branch_compare_pipe.sv
// tb_ama_riscv_branch_compare_pipe: directed vectors, stall/flush/reset sequences and random sweep over several configs
module tb_ama_riscv_branch_compare_pipe;
  localparam int NR = 400;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic        eq, lt, tk, er;
  } vec_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [2:0] in_funct3 = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic [3:0] in_tag = 0;
  logic in_ready, out_valid, out_eq, out_lt, out_taken, out_err;
  logic [3:0] out_tag;
  logic rv = 0;
  logic [2:0] rf3 = 0;
  logic [63:0] ra = 0, rb = 0;
  logic [3:0] rtag = 0;
  logic u1_ir, u1_ov, u1_eq, u1_lt, u1_tk, u1_er;
  logic u4_ir, u4_ov, u4_eq, u4_lt, u4_tk, u4_er;
  logic uw_ir, uw_ov, uw_eq, uw_lt, uw_tk, uw_er;
  logic [3:0] u1_tag, u4_tag, uw_tag;
  int checks = 0, failures = 0;
  vec_t vt [15];
  logic hv [NR];
  logic [63:0] ha [NR];
  logic [63:0] hb [NR];
  logic [2:0] hf [NR];
  logic [3:0] ht [NR];
  logic [3:0] rq [$];

  always #5 clk = ~clk;

  ama_riscv_branch_compare_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_eq(out_eq), .out_lt(out_lt),
    .out_taken(out_taken), .out_err(out_err), .out_tag(out_tag));

  ama_riscv_branch_compare_pipe #(.XLEN(32), .STAGES(1), .TAG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(rv), .in_ready(u1_ir),
    .in_funct3(rf3), .in_a(ra[31:0]), .in_b(rb[31:0]), .in_tag(rtag),
    .out_valid(u1_ov), .out_ready(1'b1), .out_eq(u1_eq), .out_lt(u1_lt),
    .out_taken(u1_tk), .out_err(u1_er), .out_tag(u1_tag));

  ama_riscv_branch_compare_pipe #(.XLEN(32), .STAGES(4), .TAG_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(rv), .in_ready(u4_ir),
    .in_funct3(rf3), .in_a(ra[31:0]), .in_b(rb[31:0]), .in_tag(rtag),
    .out_valid(u4_ov), .out_ready(1'b1), .out_eq(u4_eq), .out_lt(u4_lt),
    .out_taken(u4_tk), .out_err(u4_er), .out_tag(u4_tag));

  ama_riscv_branch_compare_pipe #(.XLEN(64), .STAGES(4), .TAG_W(4)) uw (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(rv), .in_ready(uw_ir),
    .in_funct3(rf3), .in_a(ra), .in_b(rb), .in_tag(rtag),
    .out_valid(uw_ov), .out_ready(1'b1), .out_eq(uw_eq), .out_lt(uw_lt),
    .out_taken(uw_tk), .out_err(uw_er), .out_tag(uw_tag));

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Reference: plain whole-word compares, then the branch table
  function automatic logic [3:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [2:0] f, input int xl);
    logic e, l, t, r;
    if (xl == 32) begin
      e = a[31:0] == b[31:0];
      l = f[1] ? (a[31:0] < b[31:0]) : ($signed(a[31:0]) < $signed(b[31:0]));
    end else begin
      e = a == b;
      l = f[1] ? (a < b) : ($signed(a) < $signed(b));
    end
    r = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:         t = e;
      3'b001:         t = !e;
      3'b100, 3'b110: t = l;
      3'b101, 3'b111: t = !l;
      default:        t = 1'b0;
    endcase
    return {e, l, t, r};
  endfunction

  function automatic logic [8:0] pk(input logic v, input logic [3:0] r, input logic [3:0] t);
    return v ? {1'b1, r, t} : 9'b0;
  endfunction

  task automatic run_vec(input int i);
    int lat;
    in_funct3 = vt[i].f;
    in_a = vt[i].a;
    in_b = vt[i].b;
    in_tag = vt[i].tag;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", i), lat, 2);
    chk($sformatf("vec%0d_result", i), {out_eq, out_lt, out_taken, out_err, out_tag},
        {vt[i].eq, vt[i].lt, vt[i].tk, vt[i].er, vt[i].tag});
  endtask

  initial begin
    int sent, cnt, m;
    logic saw_block, hold, acc;
    logic [3:0] htag;
    vt[0]  = '{3'b100, 32'h00000010, 32'hFFFFFFF0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{3'b110, 32'h00000010, 32'hFFFFFFF0, 4'd4,  1'b0, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{3'b110, 32'h0000000D, 32'h00000010, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{3'b000, 32'hFFFFFFF0, 32'hFFFFFFF0, 4'd6,  1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{3'b100, 32'h12340001, 32'h12340002, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{3'b111, 32'h12340001, 32'h12340002, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{3'b001, 32'h00000005, 32'h00000005, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{3'b001, 32'h00000005, 32'h00000006, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[10] = '{3'b010, 32'h00000001, 32'h00000002, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[11] = '{3'b011, 32'h00000003, 32'h00000003, 4'd14, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{3'b000, 32'h80000000, 32'h00000000, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0};

    #1;
    chk("reset_state", {out_valid, out_eq, out_lt, out_taken, out_err, out_tag, in_ready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", in_ready, 1);

    for (int i = 0; i < 15; i++) run_vec(i);
    @(posedge clk); #1;

    sent = 0;
    saw_block = 0;
    hold = 0;
    htag = 0;
    rq.delete();
    for (int c = 0; c < 40 && rq.size() < 8; c++) begin
      in_valid = sent < 8;
      in_tag = 4'(sent);
      in_funct3 = 3'b000;
      in_a = 32'(sent);
      in_b = 0;
      out_ready = !(c >= 3 && c < 7);
      #1;
      if (sent < 8 && !in_ready) saw_block = 1;
      if (hold) chk("stall_hold", {out_valid, out_tag}, {1'b1, htag});
      hold = out_valid && !out_ready;
      htag = out_tag;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) rq.push_back(out_tag);
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("stream_count", rq.size(), 8);
    for (int i = 0; i < rq.size(); i++) chk("stream_order", rq[i], i);
    chk("stream_ready_dropped", saw_block, 1);
    repeat (3) @(posedge clk);
    #1;

    out_ready = 0;
    in_valid = 1;
    in_tag = 8;
    @(posedge clk); #1;
    in_tag = 9;
    @(posedge clk); #1;
    chk("flush_prefill", {out_valid, out_tag}, {1'b1, 4'd8});
    in_tag = 10;
    flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 0;
    in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("flush_leak", cnt, 0);

    in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      in_tag = 4'(c + 1);
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("rst_mid", {out_valid, in_ready}, 0);
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_release_empty", {out_valid, in_ready}, 2'b01);
    run_vec(0);
    run_vec(11);

    in_valid = 0;
    rv = 0;
    repeat (5) @(posedge clk);
    #1;
    for (int c = 0; c < NR; c++) begin
      rv = $urandom_range(0, 3) != 0;
      rf3 = 3'($urandom);
      ra = {$urandom, $urandom};
      m = $urandom_range(0, 3);
      rb = m == 0 ? ra : m == 1 ? ra ^ (64'd1 << $urandom_range(0, 63)) :
           m == 2 ? ra ^ 64'($urandom_range(0, 65535)) : {$urandom, $urandom};
      rtag = 4'($urandom);
      in_valid = rv;
      in_funct3 = rf3;
      in_a = ra[31:0];
      in_b = rb[31:0];
      in_tag = rtag;
      hv[c] = rv;
      ha[c] = ra;
      hb[c] = rb;
      hf[c] = rf3;
      ht[c] = rtag;
      @(posedge clk); #1;
      chk("rand_s1", pk(u1_ov, {u1_eq, u1_lt, u1_tk, u1_er}, u1_tag),
          pk(hv[c], model(ha[c], hb[c], hf[c], 32), ht[c]));
      if (c >= 1)
        chk("rand_s2", pk(out_valid, {out_eq, out_lt, out_taken, out_err}, out_tag),
            pk(hv[c-1], model(ha[c-1], hb[c-1], hf[c-1], 32), ht[c-1]));
      if (c >= 3) begin
        chk("rand_s4", pk(u4_ov, {u4_eq, u4_lt, u4_tk, u4_er}, u4_tag),
            pk(hv[c-3], model(ha[c-3], hb[c-3], hf[c-3], 32), ht[c-3]));
        chk("rand_x64", pk(uw_ov, {uw_eq, uw_lt, uw_tk, uw_er}, uw_tag),
            pk(hv[c-3], model(ha[c-3], hb[c-3], hf[c-3], 64), ht[c-3]));
      end
    end
    in_valid = 0;
    rv = 0;
    chk("rand_ready", {in_ready, u1_ir, u4_ir, uw_ir}, 4'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
